if_fetch_queue: RTL and testbench

- Reader side of the PC register: consumes the PC stream and issues fetch requests to instruction memory.
- Buffers in-order memory responses, pairs each with its PC, and hands {pc, inst} to the decode stage with valid/ready.
- Its pc_ready output drives the PC register's enable; flush handles branch/jump redirects by discarding all fetched-but-undelivered work.

---
 rtl/if_fetch_queue_if.sv | 27 ++
 rtl/if_fetch_queue.sv | 112 +++++++++++
 tb/tb_if_fetch_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus: PC stream in, imem request/response, and {pc, inst} out to decode.
// The master side is the fetch queue itself; the slave side is the surrounding pipeline and memory.
interface if_fetch_queue_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        input  pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, id_ready,
        output pc_ready, imem_req_valid, imem_addr, id_valid, id_pc, id_inst
    );

    modport slave (
        output pc_in, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data, flush, id_ready,
        input  pc_ready, imem_req_valid, imem_addr, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch queue: issues PCs to imem, pairs in-order responses with PCs; id_valid the cycle after a response.
// Backpressure: at most DEPTH fetches in flight+buffered; flush discards all and drains late responses.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_queue_if.master bus
);
    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic          live;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [AW-1:0] pc_wr, inst_wr, rd_ptr;
    logic [AW:0]   occ, icnt, drop_cnt, drop_nxt, outstanding;
    logic          credit, issue, rsp_keep, pop;

    assign outstanding = occ - icnt;

    // live holds issue off while reset is asserted and until the first edge after release
    assign credit   = live && (occ != FULL) && (state == RUN) && !bus.flush;
    assign issue    = bus.pc_valid && credit && bus.imem_req_ready;
    assign rsp_keep = (state == RUN) && bus.imem_rsp_valid && (outstanding != '0) && !bus.flush;
    assign pop      = bus.id_valid && bus.id_ready;

    assign bus.imem_req_valid = bus.pc_valid && credit;
    assign bus.pc_ready       = issue;
    assign bus.imem_addr      = bus.pc_in;
    assign bus.id_valid       = (icnt != '0) && !bus.flush;
    assign bus.id_pc          = pc_q[rd_ptr];
    assign bus.id_inst        = inst_q[rd_ptr];

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        if (bus.flush) begin
            if (state == RUN) begin
                // a response landing on the flush edge is already accounted for
                drop_nxt = outstanding - (AW+1)'(bus.imem_rsp_valid && (outstanding != '0));
            end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                drop_nxt = drop_cnt - 1'b1;
            end
            state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
        end else if (state == DRAIN) begin
            if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
                drop_nxt = drop_cnt - 1'b1;
            end
            if (drop_nxt == '0) begin
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drop_cnt <= '0;
            live     <= 1'b0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
            live     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_wr   <= '0;
            inst_wr <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            icnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (bus.flush) begin
            pc_wr   <= '0;
            inst_wr <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            icnt    <= '0;
        end else begin
            if (issue) begin
                pc_q[pc_wr] <= bus.pc_in;
                pc_wr       <= pc_wr + 1'b1;
            end
            if (rsp_keep) begin
                inst_q[inst_wr] <= bus.imem_rsp_data;
                inst_wr         <= inst_wr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue && !pop) begin
                occ <= occ + 1'b1;
            end else if (!issue && pop) begin
                occ <= occ - 1'b1;
            end
            if (rsp_keep && !pop) begin
                icnt <= icnt + 1'b1;
            end else if (!rsp_keep && pop) begin
                icnt <= icnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: per-cycle vector table plus hand sequences for reset.
module tb_if_fetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   mem_out = 0;

    always #5 clk = ~clk;

    if_fetch_queue_if bus();
    if_fetch_queue #(.DEPTH(4), .AW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        fl;
        logic        ir;
        logic        e_pr;
        logic        e_qv;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic rr,
                                input logic rv, input logic [31:0] rpc, input logic fl,
                                input logic ir, input logic e_pr, input logic e_qv,
                                input logic e_iv, input logic [31:0] e_pc);
        vec_t v;
        v.pv = pv; v.pc = pc; v.rr = rr; v.rv = rv; v.rd = inst_of(rpc);
        v.fl = fl; v.ir = ir; v.e_pr = e_pr; v.e_qv = e_qv; v.e_iv = e_iv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory-side view of requests awaiting a response; memory resets with the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_out <= 0;
        end else begin
            assert (!(bus.imem_rsp_valid && mem_out == 0))
                else $error("protocol: response with nothing outstanding");
            mem_out <= mem_out + int'(bus.pc_ready) - int'(bus.imem_rsp_valid);
        end
    end

    initial begin
        bit seen;
        bus.pc_in = 32'h0; bus.pc_valid = 1'b1; bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0; bus.flush = 1'b0; bus.id_ready = 1'b0;

        //                pv pc          rr rv rpc        fl ir  pr qv iv id_pc
        // streaming
        vt.push_back(mk(1, 32'h000, 1, 0, 32'h000, 0, 1, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h004, 1, 1, 32'h000, 0, 1, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h008, 1, 1, 32'h004, 0, 1, 1, 1, 1, 32'h000));
        vt.push_back(mk(1, 32'h00C, 1, 1, 32'h008, 0, 1, 1, 1, 1, 32'h004));
        vt.push_back(mk(0, 32'h000, 1, 1, 32'h00C, 0, 1, 0, 0, 1, 32'h008));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h00C));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 0, 32'h000));
        // backpressure until full, then resume one cycle after first pop
        vt.push_back(mk(1, 32'h100, 1, 0, 32'h000, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h104, 1, 1, 32'h100, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h108, 1, 1, 32'h104, 0, 0, 1, 1, 1, 32'h100));
        vt.push_back(mk(1, 32'h10C, 1, 1, 32'h108, 0, 0, 1, 1, 1, 32'h100));
        vt.push_back(mk(1, 32'h110, 1, 1, 32'h10C, 0, 0, 0, 0, 1, 32'h100));
        vt.push_back(mk(1, 32'h110, 1, 0, 32'h000, 0, 0, 0, 0, 1, 32'h100));
        vt.push_back(mk(1, 32'h110, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h100));
        vt.push_back(mk(1, 32'h110, 1, 0, 32'h000, 0, 0, 1, 1, 1, 32'h104));
        vt.push_back(mk(1, 32'h114, 1, 1, 32'h110, 0, 0, 0, 0, 1, 32'h104));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h104));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h108));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h10C));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h110));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 0, 32'h000));
        // memory stall for 3 cycles
        vt.push_back(mk(1, 32'h200, 0, 0, 32'h000, 0, 0, 0, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h200, 0, 0, 32'h000, 0, 0, 0, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h200, 0, 0, 32'h000, 0, 0, 0, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h200, 1, 0, 32'h000, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(0, 32'h000, 1, 1, 32'h200, 0, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h200));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 0, 32'h000));
        // flush with 2 outstanding + 1 buffered; redirect to 0x40 after drain
        vt.push_back(mk(1, 32'h300, 1, 0, 32'h000, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h304, 1, 1, 32'h300, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h308, 1, 0, 32'h000, 0, 0, 1, 1, 1, 32'h300));
        vt.push_back(mk(1, 32'h040, 1, 0, 32'h000, 1, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(1, 32'h040, 1, 1, 32'h304, 0, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(1, 32'h040, 1, 1, 32'h308, 0, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(1, 32'h040, 1, 0, 32'h000, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(0, 32'h000, 1, 1, 32'h040, 0, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h040));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 0, 32'h000));
        // flush coinciding with a response and an issue attempt: one left to drop
        vt.push_back(mk(1, 32'h500, 1, 0, 32'h000, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h504, 1, 0, 32'h000, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h508, 1, 1, 32'h500, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(1, 32'h50C, 1, 1, 32'h504, 1, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(1, 32'h50C, 1, 0, 32'h000, 0, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(1, 32'h50C, 1, 1, 32'h508, 0, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(1, 32'h50C, 1, 0, 32'h000, 0, 0, 1, 1, 0, 32'h000));
        vt.push_back(mk(0, 32'h000, 1, 1, 32'h50C, 0, 0, 0, 0, 0, 32'h000));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 1, 32'h50C));
        vt.push_back(mk(0, 32'h000, 1, 0, 32'h000, 0, 1, 0, 0, 0, 32'h000));

        // reset state
        #12;
        check("rst id_valid", 32'(bus.id_valid), 32'h0);
        check("rst pc_ready", 32'(bus.pc_ready), 32'h0);
        check("rst imem_req_valid", 32'(bus.imem_req_valid), 32'h0);
        check("rst id_pc", bus.id_pc, 32'h0);
        check("rst id_inst", bus.id_inst, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pc_valid = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vt[i]) begin
            @(negedge clk);
            bus.pc_valid = vt[i].pv; bus.pc_in = vt[i].pc; bus.imem_req_ready = vt[i].rr;
            bus.imem_rsp_valid = vt[i].rv; bus.imem_rsp_data = vt[i].rd;
            bus.flush = vt[i].fl; bus.id_ready = vt[i].ir;
            #1;
            check($sformatf("v%0d pc_ready", i), 32'(bus.pc_ready), 32'(vt[i].e_pr));
            check($sformatf("v%0d imem_req_valid", i), 32'(bus.imem_req_valid), 32'(vt[i].e_qv));
            check($sformatf("v%0d id_valid", i), 32'(bus.id_valid), 32'(vt[i].e_iv));
            if (vt[i].e_qv) check($sformatf("v%0d imem_addr", i), bus.imem_addr, vt[i].pc);
            if (vt[i].e_iv) begin
                check($sformatf("v%0d id_pc", i), bus.id_pc, vt[i].e_pc);
                check($sformatf("v%0d id_inst", i), bus.id_inst, inst_of(vt[i].e_pc));
            end
        end

        // asynchronous reset mid-stream
        @(negedge clk);
        bus.pc_valid = 1'b1; bus.pc_in = 32'h600; bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0; bus.flush = 1'b0; bus.id_ready = 1'b0;
        @(negedge clk);
        bus.pc_in = 32'h604; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = inst_of(32'h600);
        @(negedge clk);
        bus.pc_in = 32'h608; bus.imem_rsp_valid = 1'b0;
        #1;
        check("pre-reset id_valid", 32'(bus.id_valid), 32'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async id_valid", 32'(bus.id_valid), 32'h0);
        check("async pc_ready", 32'(bus.pc_ready), 32'h0);
        @(negedge clk);
        bus.pc_in = 32'h700;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            #1;
            if (bus.pc_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check("post-reset issue seen", 32'(seen), 32'h1);
        check("post-reset imem_addr", bus.imem_addr, 32'h700);
        @(negedge clk);
        bus.pc_valid = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = inst_of(32'h700);
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0; bus.id_ready = 1'b1;
        #1;
        check("post-reset id_valid", 32'(bus.id_valid), 32'h1);
        check("post-reset id_pc", bus.id_pc, 32'h700);
        check("post-reset id_inst", bus.id_inst, inst_of(32'h700));
        @(negedge clk);
        bus.id_ready = 1'b0;
        #1;
        check("post-reset empty", 32'(bus.id_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
